// File: rtl/reg_file.sv
// Architectural register file with rename tags (busy/dep) for an out-of-order core.
// Optional macro REG_FILE_BYPASS_EN forwards a matching same-cycle commit to the read ports.
module reg_file (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        rf_in_en,
  input  logic [4:0]  rf_rob_idx_in,
  input  logic [4:0]  rf_dest_in,
  input  logic [31:0] rf_val_in,
  input  logic        de_en,
  input  logic [4:0]  de_rd,
  input  logic [4:0]  de_rob_idx,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  rs1_dep,
  output logic [4:0]  rs2_dep,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val
);

  logic [31:0] val_q  [32];
  logic        busy_q [32];
  logic [4:0]  dep_q  [32];

  logic commit_ok;
  logic rename_ok;

  assign commit_ok = rdy_in && rf_in_en && (rf_dest_in != 5'd0);
  assign rename_ok = rdy_in && de_en && (de_rd != 5'd0) && !roll_back;

  // Rename is applied after commit so a same-register rename keeps busy set and wins dep.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        val_q[i]  <= 32'd0;
        busy_q[i] <= 1'b0;
        dep_q[i]  <= 5'd0;
      end
    end else if (rdy_in) begin
      if (commit_ok) begin
        val_q[rf_dest_in] <= rf_val_in;
        if (dep_q[rf_dest_in] == rf_rob_idx_in)
          busy_q[rf_dest_in] <= 1'b0;
      end
      if (roll_back) begin
        for (int i = 0; i < 32; i++)
          busy_q[i] <= 1'b0;
      end else if (rename_ok) begin
        busy_q[de_rd] <= 1'b1;
        dep_q[de_rd]  <= de_rob_idx;
      end
    end
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs1_dep  = 5'd0;
    rs1_val  = 32'd0;
    if (rs1_idx != 5'd0) begin
      rs1_busy = busy_q[rs1_idx];
      rs1_dep  = dep_q[rs1_idx];
      rs1_val  = val_q[rs1_idx];
`ifdef REG_FILE_BYPASS_EN
      if (commit_ok && rf_dest_in == rs1_idx && dep_q[rs1_idx] == rf_rob_idx_in) begin
        rs1_busy = 1'b0;
        rs1_val  = rf_val_in;
      end
`else
`endif
    end
  end

  always_comb begin
    rs2_busy = 1'b0;
    rs2_dep  = 5'd0;
    rs2_val  = 32'd0;
    if (rs2_idx != 5'd0) begin
      rs2_busy = busy_q[rs2_idx];
      rs2_dep  = dep_q[rs2_idx];
      rs2_val  = val_q[rs2_idx];
`ifdef REG_FILE_BYPASS_EN
      if (commit_ok && rf_dest_in == rs2_idx && dep_q[rs2_idx] == rf_rob_idx_in) begin
        rs2_busy = 1'b0;
        rs2_val  = rf_val_in;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, roll_back, rf_in_en, de_en;
  logic [4:0]  rf_rob_idx_in, rf_dest_in, de_rd, de_rob_idx, rs1_idx, rs2_idx;
  logic [31:0] rf_val_in;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_dep, rs2_dep;
  logic [31:0] rs1_val, rs2_val;

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned m_val  [32];
  bit          m_busy [32];
  int unsigned m_dep  [32];

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .rf_in_en(rf_in_en), .rf_rob_idx_in(rf_rob_idx_in), .rf_dest_in(rf_dest_in),
    .rf_val_in(rf_val_in), .de_en(de_en), .de_rd(de_rd), .de_rob_idx(de_rob_idx),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
    .rs1_val(rs1_val), .rs2_val(rs2_val)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected read result: stored model state, zero for x0, optional commit forwarding.
  task automatic exp_read(input int r, output logic b, output logic [4:0] d, output logic [31:0] v);
    b = 1'b0; d = 5'd0; v = 32'd0;
    if (r != 0) begin
      b = m_busy[r]; d = 5'(m_dep[r]); v = m_val[r];
`ifdef REG_FILE_BYPASS_EN
      if (rdy_in && rf_in_en && int'(rf_dest_in) == r && m_dep[r] == rf_rob_idx_in) begin
        b = 1'b0; v = rf_val_in;
      end
`endif
    end
  endtask

  task automatic check_reads(input string tag);
    logic b; logic [4:0] d; logic [31:0] v;
    exp_read(int'(rs1_idx), b, d, v);
    check({tag, "_rs1_busy"}, 32'(rs1_busy), 32'(b));
    check({tag, "_rs1_dep"},  32'(rs1_dep),  32'(d));
    check({tag, "_rs1_val"},  rs1_val,       v);
    exp_read(int'(rs2_idx), b, d, v);
    check({tag, "_rs2_busy"}, 32'(rs2_busy), 32'(b));
    check({tag, "_rs2_dep"},  32'(rs2_dep),  32'(d));
    check({tag, "_rs2_val"},  rs2_val,       v);
  endtask

  task automatic model_update();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_dep[i] = 0; end
    end else if (rdy_in) begin
      int cd = int'(rf_dest_in);
      int rd = int'(de_rd);
      if (rf_in_en && cd != 0) begin
        m_val[cd] = rf_val_in;
        if (m_dep[cd] == rf_rob_idx_in) m_busy[cd] = 0;
      end
      if (roll_back) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (de_en && rd != 0) begin
        m_busy[rd] = 1; m_dep[rd] = de_rob_idx;
      end
    end
  endtask

  task automatic tick(input string tag);
    #1;
    check_reads(tag);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; roll_back = 0; rf_in_en = 0; de_en = 0;
    rf_rob_idx_in = 0; rf_dest_in = 0; rf_val_in = 0; de_rd = 0; de_rob_idx = 0;
  endtask

  initial begin
    idle();
    rs1_idx = 5; rs2_idx = 0;
    rst_in = 1;
    @(negedge clk);
    model_update();
    @(posedge clk); #1;
    rst_in = 0;

    // reset readback
    #1;
    check("rst_x5_busy", 32'(rs1_busy), 32'd0);
    check("rst_x5_dep",  32'(rs1_dep),  32'd0);
    check("rst_x5_val",  rs1_val,       32'd0);

    // rename then matching commit
    de_en = 1; de_rd = 3; de_rob_idx = 7; rs1_idx = 3;
    tick("ren_x3");
    idle();
    rf_in_en = 1; rf_rob_idx_in = 7; rf_dest_in = 3; rf_val_in = 32'h1234;
    #1;
    check("x3_dep_pre", 32'(rs1_dep), 32'd7);
`ifdef REG_FILE_BYPASS_EN
    check("x3_busy_byp", 32'(rs1_busy), 32'd0);
    check("x3_val_byp",  rs1_val,       32'h1234);
`else
    check("x3_busy_pre", 32'(rs1_busy), 32'd1);
    check("x3_val_pre",  rs1_val,       32'd0);
`endif
    tick("com_x3");
    idle();
    #1;
    check("x3_busy_post", 32'(rs1_busy), 32'd0);
    check("x3_val_post",  rs1_val,       32'h1234);

    // older commit must not clear a younger rename
    de_en = 1; de_rd = 4; de_rob_idx = 2; rs1_idx = 4;
    tick("ren_x4a");
    de_rob_idx = 9;
    tick("ren_x4b");
    idle();
    rf_in_en = 1; rf_rob_idx_in = 2; rf_dest_in = 4; rf_val_in = 32'hAA;
    tick("com_x4");
    idle();
    #1;
    check("x4_val",  rs1_val,       32'hAA);
    check("x4_busy", 32'(rs1_busy), 32'd1);
    check("x4_dep",  32'(rs1_dep),  32'd9);

    // same-cycle commit and rename of x6
    rf_in_en = 1; rf_rob_idx_in = 1; rf_dest_in = 6; rf_val_in = 32'h55;
    de_en = 1; de_rd = 6; de_rob_idx = 12; rs1_idx = 6;
    #1;
    check("x6_busy_pre", 32'(rs1_busy), 32'd0);
    check("x6_val_pre",  rs1_val,       32'd0);
    tick("cr_x6");
    idle();
    #1;
    check("x6_val",  rs1_val,       32'h55);
    check("x6_busy", 32'(rs1_busy), 32'd1);
    check("x6_dep",  32'(rs1_dep),  32'd12);

    // rollback with a coincident rename
    de_en = 1; de_rd = 1; de_rob_idx = 4;
    tick("ren_x1");
    de_rd = 2; de_rob_idx = 5;
    tick("ren_x2");
    de_rd = 8; de_rob_idx = 3; roll_back = 1;
    tick("rb");
    idle();
    rs1_idx = 1; rs2_idx = 2;
    #1;
    check("rb_x1_busy", 32'(rs1_busy), 32'd0);
    check("rb_x2_busy", 32'(rs2_busy), 32'd0);
    rs1_idx = 8; rs2_idx = 3;
    #1;
    check("rb_x8_busy", 32'(rs1_busy), 32'd0);
    check("rb_x3_val",  rs2_val,       32'h1234);
    rs1_idx = 4; rs2_idx = 6;
    #1;
    check("rb_x4_val", rs1_val, 32'hAA);
    check("rb_x6_val", rs2_val, 32'h55);

    // writes to x0 are ignored
    rf_in_en = 1; rf_dest_in = 0; rf_val_in = 32'hFFFF_FFFF; de_en = 1; de_rd = 0; de_rob_idx = 6;
    tick("x0_wr");
    idle();
    rs1_idx = 0;
    #1;
    check("x0_val",  rs1_val,       32'd0);
    check("x0_busy", 32'(rs1_busy), 32'd0);

    // stalled cycle changes nothing
    rdy_in = 0; rf_in_en = 1; rf_dest_in = 5; rf_rob_idx_in = 0; rf_val_in = 32'hDEAD;
    de_en = 1; de_rd = 5; de_rob_idx = 11; rs2_idx = 5;
    tick("stall");
    idle();
    #1;
    check("stall_x5_val",  rs2_val,       32'd0);
    check("stall_x5_busy", 32'(rs2_busy), 32'd0);

    // random traffic over a small register/ROB window to provoke collisions
    for (int n = 0; n < 2000; n++) begin
      rst_in        = ($urandom_range(0, 199) == 0);
      rdy_in        = ($urandom_range(0, 9) != 0);
      roll_back     = ($urandom_range(0, 19) == 0);
      rf_in_en      = $urandom_range(0, 1);
      rf_rob_idx_in = 5'($urandom_range(0, 3));
      rf_dest_in    = 5'($urandom_range(0, 7));
      rf_val_in     = $urandom;
      de_en         = $urandom_range(0, 1);
      de_rd         = 5'($urandom_range(0, 7));
      de_rob_idx    = 5'($urandom_range(0, 3));
      rs1_idx       = 5'($urandom_range(0, 7));
      rs2_idx       = 5'($urandom_range(0, 31));
      tick("rnd");
    end
    idle();
    tick("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
